phy_rx_deserializer: RTL and testbench

//  Receive end of the PHY serial link. Samples one serial bit per clk_8f, MSB first.

---
 rtl/phy_rx_deserializer.sv | 112 +++++++++++
 tb/tb_phy_rx_deserializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_deserializer.sv
// Serial-to-parallel receiver: aligns on a comma symbol, locks after LOCK_COUNT
// consecutive aligned commas, then emits one byte every 8 bit clocks.
module phy_rx_deserializer #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         LOCK_COUNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_ALIGN,
    ST_ACTIVE
  } state_t;

  localparam logic [3:0] LC = 4'(LOCK_COUNT);

  state_t     r_state;
  // Only the low seven history bits are ever combined with the incoming bit.
  logic [6:0] r_sr;
  logic [2:0] r_bit_cnt;
  logic [3:0] r_bc_cnt;
  logic [7:0] r_data_out;
  logic       r_valid_out;
  logic       r_byte_strobe;
  logic       r_active;

  logic [7:0] w_next_byte;
  logic       w_is_comma;
  logic       w_boundary;
  logic [3:0] w_bc_plus1;
  logic [3:0] w_bc_sat;

  assign w_next_byte = {r_sr, data_in};
  assign w_is_comma  = (w_next_byte == COMMA);
  assign w_boundary  = (r_bit_cnt == 3'd7);
  assign w_bc_plus1  = r_bc_cnt + 4'd1;
  assign w_bc_sat    = (r_bc_cnt == LC) ? LC : w_bc_plus1;

  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      r_state       <= ST_SEARCH;
      r_sr          <= '0;
      r_bit_cnt     <= '0;
      r_bc_cnt      <= '0;
      r_data_out    <= 8'h00;
      r_valid_out   <= 1'b0;
      r_byte_strobe <= 1'b0;
      r_active      <= 1'b0;
    end else begin
      r_sr          <= w_next_byte[6:0];
      r_byte_strobe <= 1'b0;
      case (r_state)
        ST_SEARCH: begin
          // Any bit offset is a candidate; the comma edge becomes boundary phase 0.
          if (w_is_comma) begin
            r_bit_cnt <= 3'd0;
            r_bc_cnt  <= 4'd1;
            if (LC == 4'd1) begin
              r_state  <= ST_ACTIVE;
              r_active <= 1'b1;
            end else begin
              r_state <= ST_ALIGN;
            end
          end
        end
        ST_ALIGN: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_boundary) begin
            if (w_is_comma) begin
              r_bc_cnt <= w_bc_sat;
              if (w_bc_plus1 == LC) begin
                r_state  <= ST_ACTIVE;
                r_active <= 1'b1;
              end
            end else begin
              // The mismatching byte is dropped, not re-scanned at other offsets.
              r_bc_cnt <= 4'd0;
              r_state  <= ST_SEARCH;
            end
          end
        end
        ST_ACTIVE: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_boundary) begin
            r_data_out    <= w_next_byte;
            r_valid_out   <= !w_is_comma;
            r_byte_strobe <= 1'b1;
            if (w_is_comma) begin
              r_bc_cnt <= w_bc_sat;
            end
          end
        end
        default: begin
          r_state <= ST_SEARCH;
        end
      endcase
    end
  end

  assign data_out    = r_data_out;
  assign valid_out   = r_valid_out;
  assign byte_strobe = r_byte_strobe;
  assign active      = r_active;

endmodule

// File: tb/tb_phy_rx_deserializer.sv
// Directed bench for phy_rx_deserializer: lock sequences, byte table, reset and LOCK_COUNT=1.
module tb_phy_rx_deserializer;

  typedef struct {
    logic [7:0] in_byte;
    logic [7:0] exp_data;
    logic       exp_valid;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       reset1;
  logic       data_in;
  logic [7:0] data_out,  data_out1;
  logic       valid_out, valid_out1;
  logic       byte_strobe, byte_strobe1;
  logic       active, active1;

  int         checks;
  int         failures;
  logic       strobe_seen;
  logic       strobe_seen1;
  logic [7:0] mid_data;
  logic [7:0] comma_v;
  vec_t       vecs[6];

  phy_rx_deserializer #(.COMMA(8'hBC), .LOCK_COUNT(4)) dut (
    .clk_8f(clk), .reset(reset), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out),
    .byte_strobe(byte_strobe), .active(active)
  );

  phy_rx_deserializer #(.COMMA(8'hBC), .LOCK_COUNT(1)) dut1 (
    .clk_8f(clk), .reset(reset1), .data_in(data_in),
    .data_out(data_out1), .valid_out(valid_out1),
    .byte_strobe(byte_strobe1), .active(active1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one bit, clock it in, then settle 1 time unit past the edge.
  task automatic tick(input logic b);
    data_in = b;
    @(posedge clk);
    #1;
  endtask

  // Send a byte MSB first; record any strobe on bits 0..6 and data_out after bit 0.
  task automatic send_byte(input logic [7:0] b);
    strobe_seen  = 1'b0;
    strobe_seen1 = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      tick(b[i]);
      if (i == 7) mid_data = data_out;
      if (i != 0) begin
        strobe_seen  = strobe_seen | byte_strobe;
        strobe_seen1 = strobe_seen1 | byte_strobe1;
      end
    end
    $display("byte in=%02h data_out=%02h valid=%0b strobe=%0b active=%0b",
             b, data_out, valid_out, byte_strobe, active);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_active", {31'd0, active}, 32'd0);
    chk("rst_data", {24'd0, data_out}, 32'd0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_strobe", {31'd0, byte_strobe}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    comma_v  = 8'hBC;
    data_in  = 1'b0;
    reset    = 1'b1;
    reset1   = 1'b1;
    vecs[0] = '{8'hAA, 8'hAA, 1'b1};
    vecs[1] = '{8'h3A, 8'h3A, 1'b1};
    vecs[2] = '{8'hBC, 8'hBC, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1};
    vecs[5] = '{8'h5D, 8'h5D, 1'b1};

    // 1: reset state, then four aligned commas
    repeat (2) @(posedge clk);
    #1;
    chk("t1_rst_active", {31'd0, active}, 32'd0);
    chk("t1_rst_data", {24'd0, data_out}, 32'd0);
    chk("t1_rst_valid", {31'd0, valid_out}, 32'd0);
    chk("t1_rst_strobe", {31'd0, byte_strobe}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send_byte(comma_v);
      chk("t1_no_lock_yet", {31'd0, active}, 32'd0);
      chk("t1_no_strobe", {31'd0, strobe_seen | byte_strobe}, 32'd0);
    end
    for (int i = 7; i >= 1; i--) tick(comma_v[i]);
    chk("t1_active_before_last_bit", {31'd0, active}, 32'd0);
    tick(comma_v[0]);
    chk("t1_active_on_last_bit", {31'd0, active}, 32'd1);
    chk("t1_no_strobe_on_lock", {31'd0, byte_strobe}, 32'd0);

    // 2: table-driven bytes on the locked link
    for (int v = 0; v < 6; v++) begin
      send_byte(vecs[v].in_byte);
      chk("t2_mid_no_strobe", {31'd0, strobe_seen}, 32'd0);
      if (v > 0) chk("t2_mid_hold", {24'd0, mid_data}, {24'd0, vecs[v-1].exp_data});
      chk("t2_strobe", {31'd0, byte_strobe}, 32'd1);
      chk("t2_data", {24'd0, data_out}, {24'd0, vecs[v].exp_data});
      chk("t2_valid", {31'd0, valid_out}, {31'd0, vecs[v].exp_valid});
      chk("t2_active", {31'd0, active}, 32'd1);
    end

    // 3: three garbage bits, lock at offset 3, first output 0x5D
    do_reset();
    tick(1'b0); tick(1'b1); tick(1'b0);
    for (int k = 0; k < 4; k++) begin
      send_byte(comma_v);
      chk("t3_no_strobe", {31'd0, strobe_seen | byte_strobe}, 32'd0);
    end
    chk("t3_active", {31'd0, active}, 32'd1);
    send_byte(8'h5D);
    chk("t3_mid_no_strobe", {31'd0, strobe_seen}, 32'd0);
    chk("t3_strobe", {31'd0, byte_strobe}, 32'd1);
    chk("t3_data", {24'd0, data_out}, 32'h5D);
    chk("t3_valid", {31'd0, valid_out}, 32'd1);

    // 4: broken alignment attempt, then a clean lock
    do_reset();
    send_byte(comma_v);
    chk("t4_a_active", {31'd0, active}, 32'd0);
    send_byte(comma_v);
    chk("t4_b_active", {31'd0, active}, 32'd0);
    send_byte(8'h81);
    chk("t4_c_active", {31'd0, active}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      send_byte(comma_v);
      chk("t4_relock_pending", {31'd0, active}, 32'd0);
    end
    send_byte(comma_v);
    chk("t4_relock", {31'd0, active}, 32'd1);
    chk("t4_no_strobe", {31'd0, byte_strobe}, 32'd0);
    send_byte(8'h5D);
    chk("t4_data", {24'd0, data_out}, 32'h5D);
    chk("t4_strobe", {31'd0, byte_strobe}, 32'd1);

    // 5: asynchronous reset at bit 4 of a byte while ACTIVE
    tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b0);
    chk("t5_pre_active", {31'd0, active}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_active", {31'd0, active}, 32'd0);
    chk("t5_async_valid", {31'd0, valid_out}, 32'd0);
    chk("t5_async_data", {24'd0, data_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send_byte(comma_v);
      chk("t5_relock_pending", {31'd0, active}, 32'd0);
    end
    send_byte(comma_v);
    chk("t5_relock", {31'd0, active}, 32'd1);

    // 6: LOCK_COUNT=1 instance locks on a single comma
    @(negedge clk);
    reset1 = 1'b0;
    send_byte(comma_v);
    chk("t6_active", {31'd0, active1}, 32'd1);
    chk("t6_no_strobe", {31'd0, strobe_seen1 | byte_strobe1}, 32'd0);
    send_byte(8'h90);
    chk("t6_mid_no_strobe", {31'd0, strobe_seen1}, 32'd0);
    chk("t6_strobe", {31'd0, byte_strobe1}, 32'd1);
    chk("t6_data", {24'd0, data_out1}, 32'h90);
    chk("t6_valid", {31'd0, valid_out1}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
